// File: rtl/morse_decoder.sv
// morse_decoder: tick-timed Morse key decoder emitting a 6-bit character code per letter
module morse_decoder #(
  parameter int DASH_UNITS = 2,
  parameter int GAP_UNITS  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  input  logic       tick,
  output logic [5:0] char_code,
  output logic       char_valid,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, MARK, SPACE, EMIT} state_t;
  localparam logic [3:0] DASH_C = 4'(DASH_UNITS);
  localparam logic [3:0] GAP_C  = 4'(GAP_UNITS);
  state_t state_q, state_d;
  logic [4:0] sym_q, sym_d;
  logic [2:0] len_q, len_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic [5:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  // first symbol of a letter sits at bit len-1, dot = 0, dash = 1
  function automatic logic [5:0] lookup(input logic [2:0] l, input logic [4:0] s);
    case ({l, s})
      8'b001_00000: lookup = 6'd14;
      8'b001_00001: lookup = 6'd29;
      8'b010_00000: lookup = 6'd18;
      8'b010_00001: lookup = 6'd10;
      8'b010_00010: lookup = 6'd23;
      8'b010_00011: lookup = 6'd22;
      8'b011_00000: lookup = 6'd28;
      8'b011_00001: lookup = 6'd30;
      8'b011_00010: lookup = 6'd27;
      8'b011_00011: lookup = 6'd32;
      8'b011_00100: lookup = 6'd13;
      8'b011_00101: lookup = 6'd20;
      8'b011_00110: lookup = 6'd16;
      8'b011_00111: lookup = 6'd24;
      8'b100_00000: lookup = 6'd17;
      8'b100_00001: lookup = 6'd31;
      8'b100_00010: lookup = 6'd15;
      8'b100_00100: lookup = 6'd21;
      8'b100_00110: lookup = 6'd25;
      8'b100_00111: lookup = 6'd19;
      8'b100_01000: lookup = 6'd11;
      8'b100_01001: lookup = 6'd33;
      8'b100_01010: lookup = 6'd12;
      8'b100_01011: lookup = 6'd34;
      8'b100_01100: lookup = 6'd35;
      8'b100_01101: lookup = 6'd26;
      8'b101_11111: lookup = 6'd0;
      8'b101_01111: lookup = 6'd1;
      8'b101_00111: lookup = 6'd2;
      8'b101_00011: lookup = 6'd3;
      8'b101_00001: lookup = 6'd4;
      8'b101_00000: lookup = 6'd5;
      8'b101_10000: lookup = 6'd6;
      8'b101_11000: lookup = 6'd7;
      8'b101_11100: lookup = 6'd8;
      8'b101_11110: lookup = 6'd9;
      default:      lookup = 6'd63;
    endcase
  endfunction
  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    code_d  = code_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        sym_d   = '0;
        len_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
        state_d = key ? MARK : IDLE;
      end
      MARK: begin
        if (!key) begin
          ovf_d   = ovf_q | (len_q == 3'd5);
          sym_d   = (len_q == 3'd5) ? sym_q : {sym_q[3:0], cnt_q >= DASH_C};
          len_d   = (len_q == 3'd5) ? len_q : len_q + 3'd1;
          cnt_d   = '0;
          state_d = SPACE;
        end else if (tick && cnt_q != 4'hf) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SPACE: begin
        if (key) begin
          cnt_d   = '0;
          state_d = MARK;
        end else if (tick) begin
          cnt_d = (cnt_q == 4'hf) ? cnt_q : cnt_q + 4'd1;
          if (cnt_d >= GAP_C) begin
            state_d = EMIT;
            code_d  = ovf_q ? 6'd63 : lookup(len_q, sym_q);
            valid_d = 1'b1;
          end
        end
      end
      EMIT: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sym_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      code_q  <= 6'd63;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end
  assign char_code  = code_q;
  assign char_valid = valid_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: random Morse letters checked against a dot/dash string table model
module tb_morse_decoder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic key = 1'b0;
  logic tick = 1'b0;
  logic [5:0] char_code;
  logic char_valid;
  logic busy;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_pulses = 0;
  string tbl[36] = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                     "---..", "----.", ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                     "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...",
                     "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
  always #5 clk = ~clk;
  morse_decoder dut (
    .clk(clk),
    .reset(reset),
    .key(key),
    .tick(tick),
    .char_code(char_code),
    .char_valid(char_valid),
    .busy(busy)
  );
  always @(negedge clk) if (char_valid) pulses++;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask
  function automatic int model(input string p);
    if (p.len() > 5) return 63;
    foreach (tbl[i]) if (tbl[i] == p) return i;
    return 63;
  endfunction
  // one Morse unit: 4 cycles, tick on the third; key may change on the tick cycle
  task automatic unit(input logic k, input logic kt, output logic v, output logic [5:0] c);
    key = k;
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    key = kt;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    v = char_valid;
    c = char_code;
    @(negedge clk);
  endtask
  task automatic gap_expect(input string tag, input int exp);
    logic v;
    logic [5:0] c;
    unit(1'b0, 1'b0, v, c);
    chk({tag, "_gap1"}, int'(v), 0);
    unit(1'b0, 1'b0, v, c);
    chk({tag, "_gap2"}, int'(v), 0);
    unit(1'b0, 1'b0, v, c);
    chk({tag, "_valid"}, int'(v), 1);
    chk({tag, "_code"}, int'(c), exp);
    exp_pulses++;
  endtask
  task automatic send(input string p, input int exp);
    logic v;
    logic [5:0] c;
    int n;
    for (int i = 0; i < p.len(); i++) begin
      n = (p[i] == "-") ? int'($urandom_range(2, 4)) : 1;
      repeat (n) unit(1'b1, 1'b1, v, c);
      if (i < p.len() - 1)
        repeat ($urandom_range(1, 2)) begin
          unit(1'b0, 1'b0, v, c);
          chk("intra_gap", int'(v), 0);
        end
    end
    gap_expect({"letter ", p}, exp);
    repeat ($urandom_range(0, 1)) unit(1'b0, 1'b0, v, c);
  endtask
  initial begin
    logic v;
    logic [5:0] c;
    string p;
    repeat (2) @(negedge clk);
    chk("rst_code", int'(char_code), 63);
    chk("rst_valid", int'(char_valid), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b1;
    send(".-", 10);
    send("-----", 0);
    send(".", 14);
    send("......", 63);
    send("-", 29);
    unit(1'b1, 1'b1, v, c);
    unit(1'b1, 1'b0, v, c);
    gap_expect("release_on_tick", 14);
    unit(1'b1, 1'b1, v, c);
    unit(1'b0, 1'b0, v, c);
    unit(1'b1, 1'b1, v, c);
    chk("mark_busy", int'(busy), 1);
    unit(1'b0, 1'b0, v, c);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_code", int'(char_code), 63);
    chk("midrst_valid", int'(char_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    repeat (3) begin
      unit(1'b0, 1'b0, v, c);
      chk("midrst_silent", int'(v), 0);
    end
    send(".", 14);
    unit(1'b1, 1'b1, v, c);
    unit(1'b0, 1'b0, v, c);
    unit(1'b0, 1'b0, v, c);
    unit(1'b0, 1'b1, v, c);
    chk("key_beats_gap", int'(v), 0);
    chk("key_beats_busy", int'(busy), 1);
    unit(1'b1, 1'b1, v, c);
    unit(1'b1, 1'b1, v, c);
    gap_expect("appended", 10);
    repeat (30) begin
      if ($urandom_range(0, 1) == 1) p = tbl[$urandom_range(0, 35)];
      else begin
        p = "";
        repeat ($urandom_range(1, 7)) begin
          if ($urandom_range(0, 1) == 1) p = {p, "-"};
          else p = {p, "."};
        end
      end
      send(p, model(p));
    end
    repeat (2) unit(1'b0, 1'b0, v, c);
    chk("pulse_count", pulses, exp_pulses);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
